// File: rtl/ml_matmul2x2_core_if.sv
// ml_matmul2x2_core_if: operand-in and result-out valid/ready bundle.
// master drives operands and res_ready; slave is the core.
interface ml_matmul2x2_core_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+1
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_ready;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/ml_matmul2x2_core.sv
// ml_matmul2x2_core: streams in A then B (2x2, signed), computes C=AxB
// with one MAC per cycle, streams C out, then pulses done.
// Ports: clk, reset (async, active-high), compute_en (hold high for
// the whole op), bus (slave: in_valid/in_data/in_ready,
// res_valid/res_data/res_ready), busy (state!=IDLE), done (1-cycle).
module ml_matmul2x2_core #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      compute_en,
  ml_matmul2x2_core_if.slave        bus,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [2:0] r_lidx;
  logic [2:0] r_step;
  logic [1:0] r_ridx;

  logic signed [DATA_W-1:0] r_a [4];
  logic signed [DATA_W-1:0] r_b [4];
  logic signed [ACC_W-1:0]  r_c [4];
  logic signed [ACC_W-1:0]  r_acc;

  logic             r_in_ready;
  logic             r_res_valid;
  logic [ACC_W-1:0] r_res_data;
  logic             r_busy;
  logic             r_done;

  logic w_acc;
  logic w_res_hs;

  // Operand selection: A is stored {row,col}, B is stored {row,col}.
  // Term t picks column t of A's row i and row t of B's column j.
  logic                       w_i;
  logic                       w_j;
  logic                       w_t;
  logic signed [DATA_W-1:0]   w_opa;
  logic signed [DATA_W-1:0]   w_opb;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_x;

  assign w_i      = r_step[2];
  assign w_j      = r_step[1];
  assign w_t      = r_step[0];
  assign w_opa    = r_a[{w_i, w_t}];
  assign w_opb    = r_b[{w_t, w_j}];
  assign w_prod   = w_opa * w_opb;
  assign w_prod_x = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  assign w_acc    = (r_state == S_LOAD) && bus.in_valid && compute_en;
  assign w_res_hs = r_res_valid && bus.res_ready;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (compute_en) w_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!compute_en)                  w_nxt = S_IDLE;
        else if (w_acc && r_lidx == 3'd7) w_nxt = S_MAC;
      end
      S_MAC: begin
        if (!compute_en)          w_nxt = S_IDLE;
        else if (r_step == 3'd7)  w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!compute_en)                     w_nxt = S_IDLE;
        else if (w_res_hs && r_ridx == 2'd3) w_nxt = S_FIN;
      end
      S_FIN:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lidx      <= '0;
      r_step      <= '0;
      r_ridx      <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
        r_c[n] <= '0;
      end
    end else begin
      r_state     <= w_nxt;
      r_in_ready  <= (w_nxt == S_LOAD);
      r_res_valid <= (w_nxt == S_DRAIN);
      r_busy      <= (w_nxt != S_IDLE);
      r_done      <= (w_nxt == S_FIN);

      if (w_nxt != S_LOAD) r_lidx <= '0;
      else if (w_acc)      r_lidx <= r_lidx + 3'd1;

      if (w_acc) begin
        if (!r_lidx[2]) r_a[r_lidx[1:0]] <= bus.in_data;
        else            r_b[r_lidx[1:0]] <= bus.in_data;
      end

      if (r_state == S_MAC && compute_en) begin
        r_step <= r_step + 3'd1;
        if (!w_t) r_acc <= w_prod_x;
        else      r_c[r_step[2:1]] <= r_acc + w_prod_x;
      end else begin
        r_step <= '0;
      end

      if (w_nxt != S_DRAIN)                       r_ridx <= '0;
      else if (r_state == S_DRAIN && w_res_hs)    r_ridx <= r_ridx + 2'd1;

      // Result register tracks C[ridx]; on entry C[0] is already final
      // (C[3] is the one written on the entry edge).
      if (w_nxt != S_DRAIN)        r_res_data <= '0;
      else if (r_state == S_MAC)   r_res_data <= r_c[0];
      else if (w_res_hs)           r_res_data <= r_c[r_ridx + 2'd1];
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
